// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared widths and constants for the instruction prefetch queue.
//   FQ_WORD      instruction word width
//   FQ_AWIDTH    instruction address width
//   FQ_DEPTH     default queue depth (also the outstanding-fetch cap)
//   FQ_RESET_PC  fetch address after reset
// -----------------------------------------------------------------------------
package fetch_queue_pkg;
   localparam int FQ_WORD   = 16;
   localparam int FQ_AWIDTH = 16;
   localparam int FQ_DEPTH  = 4;
   localparam logic [FQ_AWIDTH-1:0] FQ_RESET_PC = '0;
endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the prefetch stage's memory-side and decode-side handshakes.
//   imem_req/imem_addr/imem_ack      fetch request channel
//   imem_rvalid/imem_rdata           in-order fetch response channel
//   redirect/redirect_pc/stall_fetch control from the processor
//   ir_valid/ir/ir_pc/ir_ready       queue head towards decode
// master = prefetch stage, slave = memory + processor environment.
// -----------------------------------------------------------------------------
interface fetch_queue_if
   import fetch_queue_pkg::*;
#(
   parameter int WIDTH  = FQ_WORD,
   parameter int AWIDTH = FQ_AWIDTH
) ();
   logic              imem_req;
   logic [AWIDTH-1:0] imem_addr;
   logic              imem_ack;
   logic              imem_rvalid;
   logic [WIDTH-1:0]  imem_rdata;
   logic              redirect;
   logic [AWIDTH-1:0] redirect_pc;
   logic              stall_fetch;
   logic              ir_valid;
   logic [WIDTH-1:0]  ir;
   logic [AWIDTH-1:0] ir_pc;
   logic              ir_ready;

   modport master (
      output imem_req, imem_addr, ir_valid, ir, ir_pc,
      input  imem_ack, imem_rvalid, imem_rdata, redirect, redirect_pc,
             stall_fetch, ir_ready
   );

   modport slave (
      input  imem_req, imem_addr, ir_valid, ir, ir_pc,
      output imem_ack, imem_rvalid, imem_rdata, redirect, redirect_pc,
             stall_fetch, ir_ready
   );
endinterface

// File: rtl/fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_queue_fifo
// DEPTH-entry circular buffer holding {instruction, pc} records.
//   clk, reset   clock, async active-high reset
//   i_flush      synchronous empty (wins over push/pop)
//   i_push       write i_data at tail (caller guarantees not full)
//   i_pop        advance head (caller guarantees not empty)
//   o_data       current head record (registered storage)
//   o_valid      queue not empty
//   o_count      occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue_fifo
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int DW    = FQ_WORD + FQ_AWIDTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_data,
   output logic          o_valid,
   output logic [CW-1:0] o_count
);
   localparam int PW = $clog2(DEPTH);

   logic [DEPTH-1:0][DW-1:0] r_mem;
   logic [PW-1:0]            r_wr, r_rd;
   logic [CW-1:0]            r_cnt;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem <= '0;
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + PW'(1);
         end
         if (i_pop)
            r_rd <= r_rd + PW'(1);
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd];
   assign o_valid = (r_cnt != '0);
   assign o_count = r_cnt;
endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch stage: issues sequential word fetches, buffers the
// returned words with their PCs, and hands them to decode in order. A
// redirect flushes the queue, restarts fetch at redirect_pc and arranges for
// every response still in flight to be discarded.
//   clk, reset   clock, async active-high reset
//   bus          fetch_queue_if.master (memory request/response, redirect,
//                stall_fetch, decode-side ir_valid/ir/ir_pc/ir_ready)
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH  = FQ_DEPTH,
   parameter int WIDTH  = FQ_WORD,
   parameter int AWIDTH = FQ_AWIDTH
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CW + 2;
   localparam logic [SW-1:0] CAP = SW'(DEPTH);

   logic [AWIDTH-1:0]       r_fpc;    // next fetch address
   logic [AWIDTH-1:0]       r_rpc;    // PC of the next kept response
   logic [CW-1:0]           r_outst;  // accepted fetches whose words we keep
   logic [CW-1:0]           r_disc;   // accepted fetches whose words we drop
   logic [CW-1:0]           w_count;
   logic [SW-1:0]           w_inflight;
   logic                    w_req, w_xfer, w_keep, w_drop, w_push, w_pop;
   logic                    w_valid;
   logic [WIDTH+AWIDTH-1:0] w_head;

   // Credit: every slot is claimed by a queued word or a fetch in flight, so
   // a kept response always finds room.
   assign w_inflight = SW'(w_count) + SW'(r_outst) + SW'(r_disc);
   assign w_req  = ~reset & ~bus.redirect & ~bus.stall_fetch & (w_inflight < CAP);
   assign w_xfer = w_req & bus.imem_ack;
   // Responses return in order, so the oldest r_disc of them are the stale ones.
   assign w_keep = bus.imem_rvalid & (r_disc == '0);
   assign w_drop = bus.imem_rvalid & (r_disc != '0);
   assign w_push = w_keep & ~bus.redirect;
   assign w_pop  = w_valid & bus.ir_ready;

   fetch_queue_fifo #(
      .DEPTH (DEPTH),
      .DW    (WIDTH + AWIDTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (bus.redirect),
      .i_push  (w_push),
      .i_data  ({bus.imem_rdata, r_rpc}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_valid (w_valid),
      .o_count (w_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fpc   <= AWIDTH'(FQ_RESET_PC);
         r_rpc   <= AWIDTH'(FQ_RESET_PC);
         r_outst <= '0;
         r_disc  <= '0;
      end else if (bus.redirect) begin
         r_fpc   <= bus.redirect_pc;
         r_rpc   <= bus.redirect_pc;
         // Everything in flight becomes stale. A response landing this cycle
         // is already counted in r_disc or r_outst and is dropped right now,
         // so it is subtracted once whichever counter it belonged to.
         r_disc  <= r_disc + r_outst - CW'(bus.imem_rvalid);
         r_outst <= '0;
      end else begin
         if (w_xfer)
            r_fpc <= r_fpc + AWIDTH'(1);
         if (w_keep)
            r_rpc <= r_rpc + AWIDTH'(1);
         r_outst <= r_outst + CW'(w_xfer) - CW'(w_keep);
         r_disc  <= r_disc - CW'(w_drop);
      end
   end

   assign bus.imem_req  = w_req;
   assign bus.imem_addr = r_fpc;
   assign bus.ir_valid  = w_valid;
   assign bus.ir        = w_head[WIDTH+AWIDTH-1:AWIDTH];
   assign bus.ir_pc     = w_head[AWIDTH-1:0];
endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Bench for fetch_queue: an in-order memory model returning addr^16'hA5A5,
// a fixed vector table for the back-pressure case, hand-written redirect /
// wrap / stall / reset sequences, and a randomized run against a queue-level
// reference model (epoch-tagged fetches, list of deliverable PCs).
// -----------------------------------------------------------------------------
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = FQ_DEPTH;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fetch_queue_if bus ();

   fetch_queue #(.DEPTH(DEPTH)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [15:0] addr;
      int          due;
      int          ep;
   } mreq_t;

   typedef struct {
      logic        rdy;
      logic        req;
      logic [15:0] addr;
      logic        vld;
      logic [15:0] pc;
   } vec_t;

   mreq_t       mq[$];      // fetches accepted by memory, not yet answered
   mreq_t       cur;
   logic [15:0] fq[$];      // PCs decode is still owed, oldest first
   logic [15:0] fpc;        // address the next request must carry
   logic        rv_now;
   int          cyc = 0, epoch = 0, lat = 1;
   int          vecs = 0, errs = 0;
   bit          jitter = 0, ack_rand = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.redirect = 1'b0;  bus.redirect_pc = '0;  bus.stall_fetch = 1'b0;
      bus.ir_ready = 1'b0;  bus.imem_ack = 1'b0;   bus.imem_rvalid = 1'b0;
      bus.imem_rdata = '0;
      mq.delete(); fq.delete(); epoch++; fpc = 16'h0000;
      #1;
      chk("rst_req",   bus.imem_req,  0);
      chk("rst_addr",  bus.imem_addr, 0);
      chk("rst_valid", bus.ir_valid,  0);
      chk("rst_ir",    bus.ir,        0);
      chk("rst_pc",    bus.ir_pc,     0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      cyc = 0;
   endtask

   // Memory side for this cycle, then let combinational outputs settle.
   task automatic pre();
      rv_now = 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc && (!jitter || $urandom_range(0, 3) != 0)) begin
         cur = mq.pop_front();
         rv_now = 1'b1;
      end
      bus.imem_rvalid = rv_now;
      bus.imem_rdata  = rv_now ? (cur.addr ^ 16'hA5A5) : 16'($urandom);
      bus.imem_ack    = ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
   endtask

   task automatic check_model();
      logic exp_req;
      exp_req = !bus.redirect && !bus.stall_fetch &&
                (fq.size() + mq.size() + int'(rv_now) < DEPTH);
      chk("req", bus.imem_req, exp_req);
      if (exp_req) chk("addr", bus.imem_addr, fpc);
      chk("ir_valid", bus.ir_valid, fq.size() > 0);
      if (fq.size() > 0) begin
         chk("ir_pc", bus.ir_pc, fq[0]);
         chk("ir",    bus.ir,    fq[0] ^ 16'hA5A5);
      end
   endtask

   // Update the reference at the clock edge, then move to the next negedge.
   task automatic post();
      logic xfer;
      xfer = bus.imem_req & bus.imem_ack;
      if (xfer) mq.push_back('{addr: bus.imem_addr, due: cyc + lat, ep: epoch});
      if (fq.size() > 0 && bus.ir_ready) void'(fq.pop_front());
      if (rv_now && cur.ep == epoch && !bus.redirect) fq.push_back(cur.addr);
      if (bus.redirect) begin
         fq.delete();
         epoch++;
         fpc = bus.redirect_pc;
      end else if (xfer) begin
         fpc = fpc + 16'h1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic mstep();
      pre(); check_model(); post();
   endtask

   task automatic wait_valid(input string name, input logic [15:0] pc, output int n);
      n = 0;
      while (!bus.ir_valid && n < 20) begin mstep(); n++; end
      if (!bus.ir_valid) begin
         vecs++; errs++;
         $display("FAIL %s_timeout: ir_valid got 0, expected 1 within 20 cycles", name);
      end else begin
         chk({name, "_pc"}, bus.ir_pc, pc);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[16];
      int   n;

      // ir_ready=0 for 10 cycles from reset, then 1 (1-cycle memory, ack=1).
      tbl[0]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
      tbl[1]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000};
      tbl[2]  = '{1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000};
      tbl[3]  = '{1'b0, 1'b1, 16'h0003, 1'b1, 16'h0000};
      for (int i = 4; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
      tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
      tbl[11] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0001};
      tbl[12] = '{1'b1, 1'b1, 16'h0005, 1'b1, 16'h0002};
      tbl[13] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0003};
      tbl[14] = '{1'b1, 1'b1, 16'h0007, 1'b1, 16'h0004};
      tbl[15] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0005};

      reset = 1'b1;
      @(negedge clk);
      do_reset();
      lat = 1;
      for (int i = 0; i < 16; i++) begin
         bus.ir_ready = tbl[i].rdy;
         pre();
         chk("t_req", bus.imem_req, tbl[i].req);
         if (tbl[i].req) chk("t_addr", bus.imem_addr, tbl[i].addr);
         chk("t_valid", bus.ir_valid, tbl[i].vld);
         if (tbl[i].vld) begin
            chk("t_pc", bus.ir_pc, tbl[i].pc);
            chk("t_ir", bus.ir,    tbl[i].pc ^ 16'hA5A5);
         end
         post();
      end

      // 3-cycle memory, redirect with three fetches outstanding.
      do_reset();
      lat = 3; bus.ir_ready = 1'b1; n = 0;
      for (int i = 0; i < 3; i++) begin
         pre(); check_model();
         if (bus.imem_req && bus.imem_ack) n++;
         post();
      end
      chk("a_reqs", n, 3);
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
      mstep();
      bus.redirect = 1'b0;
      wait_valid("a", 16'h0040, n);

      // Redirect while a response is landing; redirect-to-valid latency.
      do_reset();
      lat = 1; bus.ir_ready = 1'b1;
      for (int i = 0; i < 6; i++) mstep();
      bus.redirect = 1'b1; bus.redirect_pc = 16'h0100;
      mstep();
      bus.redirect = 1'b0;
      wait_valid("b", 16'h0100, n);
      chk("b_lat", n, 2);

      // Address wrap FFFE -> FFFF -> 0000.
      bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
      mstep();
      bus.redirect = 1'b0;
      wait_valid("c", 16'hFFFE, n);
      mstep();
      chk("c_valid1", bus.ir_valid, 1);
      chk("c_pc1",    bus.ir_pc,    16'hFFFF);
      mstep();
      chk("c_valid2", bus.ir_valid, 1);
      chk("c_pc2",    bus.ir_pc,    16'h0000);

      // Stall with two queued words: no requests, both drain.
      do_reset();
      lat = 1; bus.ir_ready = 1'b0;
      mstep(); mstep();
      bus.stall_fetch = 1'b1;
      for (int i = 0; i < 3; i++) mstep();
      bus.ir_ready = 1'b1; n = 0;
      while (bus.ir_valid && n < 10) begin mstep(); n++; end
      chk("d_drain", n, 2);
      bus.stall_fetch = 1'b0;
      for (int i = 0; i < 5; i++) mstep();
      do_reset();               // mid-burst reset
      pre();
      chk("d_first_req",  bus.imem_req,  1);
      chk("d_first_addr", bus.imem_addr, 0);
      post();

      // Randomized run against the reference model.
      jitter = 1; ack_rand = 1;
      for (int b = 0; b < 3; b++) begin
         do_reset();
         lat = b + 1;
         for (int i = 0; i < 600; i++) begin
            bus.ir_ready    = ($urandom_range(0, 9) < 7);
            bus.stall_fetch = ($urandom_range(0, 9) == 0);
            bus.redirect    = ($urandom_range(0, 31) == 0);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ?
                              16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            mstep();
         end
         bus.redirect = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
